ram_req_adapter: RTL and testbench

- Upstream stage for the single-port 32-bit RAM (1-cycle read latency, `rvalid` one cycle after `req`).
- Converts a host valid/ready request channel into the RAM's `req`/`rvalid` protocol.
- Buffers responses in a small FIFO so the host can backpressure read data.
- Range-checks addresses and returns an error response for out-of-range accesses without touching the RAM.

---
 rtl/ram_req_adapter.sv | 138 +++++++++++++
 tb/tb_ram_req_adapter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_adapter.sv
// Host valid/ready front end for the single-port 32-bit RAM. It range-checks addresses and buffers responses in a small FIFO.
// Optional: define RAM_ADAPTER_RSP_PARITY_EN to add per-byte even parity (rsp_par_o) to each response.
module ram_req_adapter #(
    parameter int Depth    = 128,
    parameter int RspDepth = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
`ifdef RAM_ADAPTER_RSP_PARITY_EN
    ,
    output logic [3:0]  rsp_par_o
`endif
);

    localparam int AddrLsb = $clog2(Depth) + 2;
    localparam int PtrW    = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW    = $clog2(RspDepth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(RspDepth);

    logic              inflight;
    logic              inflight_we;
    logic              err_inflight;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   fifo_cnt;
    logic [CntW+1:0]   occupancy;
    logic              in_range;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       push_rdata;
    logic [31:0]       mem_rdata [RspDepth];
    logic              mem_err   [RspDepth];
`ifdef RAM_ADAPTER_RSP_PARITY_EN
    logic [3:0]        push_par;
    logic [3:0]        mem_par   [RspDepth];
`endif

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Credits count queued entries plus the one response still in the pipe,
    // so a push can never find the FIFO full.
    assign occupancy   = {2'b00, fifo_cnt} + {{(CntW+1){1'b0}}, inflight}
                       + {{(CntW+1){1'b0}}, err_inflight};
    assign req_ready_o = !rst_i && (occupancy < (CntW+2)'(RspDepth));
    assign in_range    = (req_addr_i[31:AddrLsb] == '0);
    assign accept      = req_valid_i && req_ready_o;

    assign ram_req_o   = accept && in_range;
    assign ram_we_o    = req_we_i;
    assign ram_be_o    = req_be_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;

    assign push       = (inflight && ram_rvalid_i) || err_inflight;
    assign pop        = rsp_valid_o && rsp_ready_i;
    assign push_rdata = (err_inflight || inflight_we) ? 32'h0 : ram_rdata_i;

`ifdef RAM_ADAPTER_RSP_PARITY_EN
    always_comb begin
        push_par = '0;
        for (int i = 0; i < 4; i++) begin
            push_par[i] = ^push_rdata[i*8 +: 8];
        end
    end
    assign rsp_par_o = mem_par[rd_ptr];
`endif

    assign rsp_valid_o = (fifo_cnt != '0);
    assign rsp_rdata_o = mem_rdata[rd_ptr];
    assign rsp_err_o   = mem_err[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight     <= 1'b0;
            inflight_we  <= 1'b0;
            err_inflight <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            for (int i = 0; i < RspDepth; i++) begin
                mem_rdata[i] <= '0;
                mem_err[i]   <= 1'b0;
`ifdef RAM_ADAPTER_RSP_PARITY_EN
                mem_par[i]   <= '0;
`endif
            end
        end else begin
            inflight     <= accept && in_range;
            inflight_we  <= req_we_i;
            err_inflight <= accept && !in_range;
            if (push) begin
                mem_rdata[wr_ptr] <= push_rdata;
                mem_err[wr_ptr]   <= err_inflight;
`ifdef RAM_ADAPTER_RSP_PARITY_EN
                mem_par[wr_ptr]   <= push_par;
`endif
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // A push into a full FIFO means the credit accounting is broken.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && fifo_cnt == FullCnt));
        end
    end

endmodule

// File: tb/tb_ram_req_adapter.sv
// Scoreboard bench for ram_req_adapter: directed requests push expected responses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_ram_req_adapter;

    localparam int Depth    = 128;
    localparam int RspDepth = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_rvalid_i;
    logic [31:0] ram_rdata_i;
`ifdef RAM_ADAPTER_RSP_PARITY_EN
    logic [3:0]  rsp_par_o;
`endif

    ram_req_adapter #(.Depth(Depth), .RspDepth(RspDepth)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_be_i     (req_be_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_be_o     (ram_be_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rvalid_i (ram_rvalid_i),
        .ram_rdata_i  (ram_rdata_i)
`ifdef RAM_ADAPTER_RSP_PARITY_EN
        ,
        .rsp_par_o    (rsp_par_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          pop_cyc_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] ram_mem [Depth];
    logic        ram_rvalid_q = 1'b0;
    logic        inject_rvalid = 1'b0;
    logic [31:0] ram_rdata_q = 32'h0;
    logic [31:0] be_mask;

    assign ram_rvalid_i = ram_rvalid_q | inject_rvalid;
    assign ram_rdata_i  = ram_rdata_q;
    assign be_mask      = {{8{ram_be_o[3]}}, {8{ram_be_o[2]}}, {8{ram_be_o[1]}}, {8{ram_be_o[0]}}};

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        ram_rvalid_q <= ram_req_o;
        if (ram_req_o) begin
            if (ram_we_o) begin
                ram_mem[ram_addr_o[8:2]] <= (ram_mem[ram_addr_o[8:2]] & ~be_mask) | (ram_wdata_o & be_mask);
            end else begin
                ram_rdata_q <= ram_mem[ram_addr_o[8:2]];
            end
        end
    end

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [3:0] exp_par(logic [31:0] d);
        return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction

    // Monitor: every handshaken response must match the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            pop_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h err %0d, expected no response", rsp_rdata_o, rsp_err_o);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp_rdata", rsp_rdata_o, e.rdata);
                checkOutput("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
`ifdef RAM_ADAPTER_RSP_PARITY_EN
                checkOutput("rsp_par", {28'b0, rsp_par_o}, {28'b0, exp_par(e.rdata)});
`endif
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, output int waited, output int acc_cyc);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_be_i    = be;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        waited      = 0;
        acc_cyc     = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc_cyc = cyc;
                exp_q.push_back(rsp_t'{rdata: exp_rdata, err: exp_err});
                checkOutput("ram_req", {31'b0, ram_req_o}, {31'b0, !exp_err});
                if (!exp_err) begin
                    checkOutput("ram_addr", ram_addr_o, addr);
                    checkOutput("ram_we", {31'b0, ram_we_o}, {31'b0, we});
                    checkOutput("ram_be", {28'b0, ram_be_o}, {28'b0, be});
                    checkOutput("ram_wdata", ram_wdata_o, wdata);
                end
                @(posedge clk); #1;
                return;
            end
            waited++;
            @(posedge clk); #1;
        end
        checkOutput("accept_timeout", 32'(waited), 32'd0);
    endtask

    task automatic idle(input int n);
        req_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w, a, wr_acc, rd_acc, accepted, valid_seen;
        for (int i = 0; i < Depth; i++) ram_mem[i] = 32'hA000_0000 | 32'(i);
        rst_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0; req_be_i = 4'hF;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; rsp_ready_i = 1'b1;

        // Reset state, with a pending request that must not leak through.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_req_ready", {31'b0, req_ready_o}, 32'd0);
        checkOutput("reset_ram_req", {31'b0, ram_req_o}, 32'd0);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        checkOutput("post_reset_req_ready", {31'b0, req_ready_o}, 32'd1);
        @(posedge clk); #1;

        // Write then read back, with accept-to-response latency of two cycles.
        pop_cyc_q.delete();
        applyStimulus(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, w, wr_acc);
        applyStimulus(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, w, rd_acc);
        idle(5);
        checkOutput("t1_rsp_count", 32'(pop_cyc_q.size()), 32'd2);
        if (pop_cyc_q.size() == 2) begin
            checkOutput("t1_write_latency", 32'(pop_cyc_q[0]), 32'(wr_acc + 2));
            checkOutput("t1_read_latency", 32'(pop_cyc_q[1]), 32'(rd_acc + 2));
        end

        // Back-to-back reads at full throughput.
        pop_cyc_q.delete();
        applyStimulus(1'b0, 4'hF, 32'h0, 32'h0, 32'hA000_0000, 1'b0, w, a);
        checkOutput("t2_wait0", 32'(w), 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h4, 32'h0, 32'hA000_0001, 1'b0, w, a);
        checkOutput("t2_wait1", 32'(w), 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h8, 32'h0, 32'hA000_0002, 1'b0, w, a);
        checkOutput("t2_wait2", 32'(w), 32'd0);
        applyStimulus(1'b0, 4'hF, 32'hC, 32'h0, 32'hA000_0003, 1'b0, w, a);
        checkOutput("t2_wait3", 32'(w), 32'd0);
        idle(5);
        checkOutput("t2_rsp_count", 32'(pop_cyc_q.size()), 32'd4);
        if (pop_cyc_q.size() == 4) begin
            for (int i = 0; i < 3; i++) checkOutput("t2_consecutive", 32'(pop_cyc_q[i+1]), 32'(pop_cyc_q[i] + 1));
        end

        // Backpressure: only RspDepth requests fit while the host stalls.
        rsp_ready_i = 1'b0; accepted = 0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_be_i = 4'hF; req_addr_i = 32'h40;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (req_ready_o) begin
                exp_q.push_back(rsp_t'{rdata: 32'hA000_0010 + 32'(accepted), err: 1'b0});
                accepted++;
            end
            @(posedge clk); #1;
            req_addr_i = 32'h40 + 32'(4 * accepted);
        end
        checkOutput("t3_accept_count", 32'(accepted), 32'd3);
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("t3_ready_during_first_pop", {31'b0, req_ready_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3_ready_after_first_pop", {31'b0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        drain();

        // Out-of-range read sits in order between in-range reads.
        applyStimulus(1'b0, 4'hF, 32'h0, 32'h0, 32'hA000_0000, 1'b0, w, a);
        applyStimulus(1'b0, 4'hF, 32'h200, 32'h0, 32'h0, 1'b1, w, a);
        applyStimulus(1'b0, 4'hF, 32'h4, 32'h0, 32'hA000_0001, 1'b0, w, a);
        applyStimulus(1'b1, 4'hF, 32'h8000_0000, 32'h1234_5678, 32'h0, 1'b1, w, a);
        idle(1);
        drain();

        // Partial byte-enable write and a parity-interesting data word.
        applyStimulus(1'b1, 4'b0101, 32'h20, 32'h00AA_00BB, 32'h0, 1'b0, w, a);
        applyStimulus(1'b0, 4'hF, 32'h20, 32'h0, 32'hA0AA_00BB, 1'b0, w, a);
        applyStimulus(1'b1, 4'hF, 32'h24, 32'h0103_0700, 32'h0, 1'b0, w, a);
        applyStimulus(1'b0, 4'hF, 32'h24, 32'h0, 32'h0103_0700, 1'b0, w, a);
        idle(1);
        drain();

        // Reset with one read in flight and two queued; nothing stale may surface.
        rsp_ready_i = 1'b0;
        applyStimulus(1'b0, 4'hF, 32'h80, 32'h0, 32'hA000_0020, 1'b0, w, a);
        applyStimulus(1'b0, 4'hF, 32'h84, 32'h0, 32'hA000_0021, 1'b0, w, a);
        applyStimulus(1'b0, 4'hF, 32'h88, 32'h0, 32'hA000_0022, 1'b0, w, a);
        req_valid_i = 1'b0; rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("t5_ready_in_reset", {31'b0, req_ready_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0; inject_rvalid = 1'b1; rsp_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("t5_rsp_valid_after_reset", {31'b0, rsp_valid_o}, 32'd0);
        @(posedge clk); #1;
        inject_rvalid = 1'b0;
        valid_seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (rsp_valid_o) valid_seen++;
            @(posedge clk); #1;
        end
        checkOutput("t5_no_stale_rsp", 32'(valid_seen), 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, w, a);
        idle(1);
        drain();
        idle(3);

        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
